uart_reg_bank: RTL and testbench
================================

Name: uart_reg_bank

Overview:
- Register bank that sits directly downstream of the UART register-access interface and consumes its address/data/strobe bus.
- Holds the control, status, interrupt and general-purpose registers that a host reaches over UART.
- Provides a 32-bit free-running event counter with a coherent multi-byte read.
- Single clock domain; the read path is zero-latency so that both single and block reads from the interface sample valid data.

Parameters:
- CHIP_ID, 8'hA5, value returned at address 0x00.
- VERSION, 8'h01, value returned at address 0x01.
- NUM_GPR, 16, number of general-purpose bytes at 0x10 upward; legal range 1..16.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  8  register address from the UART interface.
- data_write_to_reg  in  8  write data.
- data_read_from_reg  out  8  read data, combinational from address.
- reg_en  in  1  access strobe, one-cycle pulse.
- write_en  in  1  write qualifier, valid only together with reg_en.
- status_in  in  8  live status inputs.
- irq_event  in  8  per-bit interrupt set pulses.
- cnt_tick  in  1  counter increment enable pulse.
- ctrl_out  out  8  CTRL register contents.
- irq_out  out  1  registered interrupt request.

Behaviour:
- Strobes:
  - wr = reg_en & write_en.
  - rd = reg_en & ~write_en.
  - When reg_en = 0, write_en is ignored.
- Register map (R = readable; W = writable; unlisted addresses read 8'h00 and ignore writes):
  - 0x00 ID: R only; returns CHIP_ID.
  - 0x01 VER: R only; returns VERSION.
  - 0x02 SCRATCH: R/W.
  - 0x03 CTRL: R/W; drives ctrl_out directly.
  - 0x04 STATUS: R only; 2-flop synchronised copy of status_in.
  - 0x05 IRQ_FLAGS: write-1-to-clear.
    - Each bit is set by the matching irq_event bit.
    - Set beats clear when both occur in the same cycle.
  - 0x06 IRQ_MASK: R/W.
  - 0x07 CNT_CTRL:
    - bit0 = enable (R/W).
    - bit1 = clear, write-only, self-clearing; always reads 0.
    - bits[7:2] read 0.
  - 0x08..0x0B CNT bytes 0..3, little-endian, R only.
  - 0x10..0x10+NUM_GPR-1: GPR array, R/W.
- Read timing:
  - data_read_from_reg is a pure combinational mux of address and the current register state.
  - Zero read latency; data is valid in the same cycle as the address.
- Write timing: a write takes effect at the clk edge where wr = 1; readback is visible the next cycle.
- irq_out:
  - Registered: irq_out <= |(IRQ_FLAGS & IRQ_MASK).
  - Latency is 1 cycle after a flag or mask change.
- Counter:
  - 32-bit; increments on cnt_tick when enable = 1.
  - Wraps from 0xFFFFFFFF to 0.
  - A clear (CNT_CTRL write with bit1 = 1) zeroes the counter that edge and beats a simultaneous tick.
  - The enable bit of the same write also takes effect that edge.
- Coherent counter read:
  - On rd at 0x08, cnt[31:8] is latched into a 24-bit shadow at that edge.
  - Address 0x08 always returns live cnt[7:0].
  - Addresses 0x09..0x0B return shadow bytes 0..2.
  - A block read 0x08..0x0B therefore returns one consistent 32-bit value.
  - Reads of 0x09..0x0B never modify the shadow.
- Reset values:
  - SCRATCH, CTRL, ctrl_out, IRQ_FLAGS, IRQ_MASK, CNT_CTRL, counter, shadow, GPRs, STATUS sync flops and irq_out are all 0.
  - data_read_from_reg follows address; e.g. it reads CHIP_ID when address = 0x00.
  - A reset asserted mid-sequence overrides any coincident strobe, event or tick.
- Simultaneous events:
  - A write to IRQ_MASK and a flag set in the same cycle both apply; irq_out reflects both one cycle later.
  - A write to an R-only address has no effect.

Test Plan:
1. Reset, then write 0x3C to 0x02, then read 0x02 -> data_read_from_reg = 0x3C. Read 0x00 -> 0xA5. Read 0x20 -> 0x00. Write 0x55 to 0x00, then read 0x00 -> still 0xA5.
2. Pulse irq_event = 0x81 with IRQ_MASK = 0x00 -> IRQ_FLAGS = 0x81, irq_out = 0. Write IRQ_MASK = 0x01 -> irq_out = 1 one cycle later. Write 0x01 to 0x05 in the same cycle as irq_event = 0x01 -> flags stay 0x81. Write 0x81 to 0x05 alone -> flags 0x00, irq_out = 0 the next cycle.
3. Write CNT_CTRL = 0x01 and apply 300 cnt_tick pulses -> CNT = 0x0000012C. Read 0x08 -> 0x2C. Apply further ticks, then read 0x09..0x0B -> 0x01, 0x00, 0x00 (shadow held).
4. Force counter to 0xFFFFFFFF via ticks from a preloaded test state, then one tick -> 0x00000000. Write CNT_CTRL = 0x03 in the same cycle as a tick -> counter = 0, enable remains 1, CNT_CTRL reads 0x01.
5. Write 0xA0+i to 0x10+i for i = 0..15, then block-read the same range -> 0xA0..0xAF. Write CTRL = 0x5A -> ctrl_out = 0x5A the next cycle.
6. Assert reset mid-write and mid-tick with all registers nonzero -> all reset values restored, irq_out = 0, ctrl_out = 0x00.

Source files
------------

// File: rtl/uart_reg_bank.sv
// rtl/uart_reg_bank.sv - UART-facing register bank with IRQ, counter and GPRs
module uart_reg_bank #(
    parameter logic [7:0] CHIP_ID = 8'hA5,
    parameter logic [7:0] VERSION = 8'h01,
    parameter int         NUM_GPR = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic [7:0] data_write_to_reg,
    output logic [7:0] data_read_from_reg,
    input  logic       reg_en,
    input  logic       write_en,
    input  logic [7:0] status_in,
    input  logic [7:0] irq_event,
    input  logic       cnt_tick,
    output logic [7:0] ctrl_out,
    output logic       irq_out
);
    localparam logic [7:0] GPR_BASE = 8'h10;

    logic        wr, rd, cnt_clr;
    logic [7:0]  scratch_q, scratch_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  status_meta_q, status_meta_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  irq_flags_q, irq_flags_d;
    logic [7:0]  irq_mask_q, irq_mask_d;
    logic        cnt_en_q, cnt_en_d;
    logic [31:0] cnt_q, cnt_d;
    logic [23:0] shadow_q, shadow_d;
    logic        irq_q, irq_d;
    logic [7:0]  gpr_q [NUM_GPR];
    logic [7:0]  gpr_d [NUM_GPR];

    assign wr      = reg_en & write_en;
    assign rd      = reg_en & ~write_en;
    assign cnt_clr = wr && (address == 8'h07) && data_write_to_reg[1];

    always_comb begin
        scratch_d     = scratch_q;
        ctrl_d        = ctrl_q;
        irq_mask_d    = irq_mask_q;
        cnt_en_d      = cnt_en_q;
        gpr_d         = gpr_q;
        status_meta_d = status_in;
        status_d      = status_meta_q;
        if (wr) begin
            case (address)
                8'h02:   scratch_d  = data_write_to_reg;
                8'h03:   ctrl_d     = data_write_to_reg;
                8'h06:   irq_mask_d = data_write_to_reg;
                8'h07:   cnt_en_d   = data_write_to_reg[0];
                default: ;
            endcase
            for (int i = 0; i < NUM_GPR; i++) begin
                if (address == GPR_BASE + 8'(i)) gpr_d[i] = data_write_to_reg;
            end
        end
        // New events win over a write-1-to-clear in the same cycle
        irq_flags_d = (irq_flags_q & ~((wr && address == 8'h05) ? data_write_to_reg : 8'h00))
                    | irq_event;
        irq_d = |(irq_flags_q & irq_mask_q);
        if (cnt_clr)                   cnt_d = '0;
        else if (cnt_tick && cnt_en_q) cnt_d = cnt_q + 32'd1;
        else                           cnt_d = cnt_q;
        // Upper bytes frozen when byte 0 is read so a block read is coherent
        shadow_d = (rd && address == 8'h08) ? cnt_q[31:8] : shadow_q;
    end

    always_comb begin
        data_read_from_reg = 8'h00;
        case (address)
            8'h00:   data_read_from_reg = CHIP_ID;
            8'h01:   data_read_from_reg = VERSION;
            8'h02:   data_read_from_reg = scratch_q;
            8'h03:   data_read_from_reg = ctrl_q;
            8'h04:   data_read_from_reg = status_q;
            8'h05:   data_read_from_reg = irq_flags_q;
            8'h06:   data_read_from_reg = irq_mask_q;
            8'h07:   data_read_from_reg = {7'd0, cnt_en_q};
            8'h08:   data_read_from_reg = cnt_q[7:0];
            8'h09:   data_read_from_reg = shadow_q[7:0];
            8'h0A:   data_read_from_reg = shadow_q[15:8];
            8'h0B:   data_read_from_reg = shadow_q[23:16];
            default: ;
        endcase
        for (int i = 0; i < NUM_GPR; i++) begin
            if (address == GPR_BASE + 8'(i)) data_read_from_reg = gpr_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scratch_q     <= '0;
            ctrl_q        <= '0;
            status_meta_q <= '0;
            status_q      <= '0;
            irq_flags_q   <= '0;
            irq_mask_q    <= '0;
            cnt_en_q      <= 1'b0;
            cnt_q         <= '0;
            shadow_q      <= '0;
            irq_q         <= 1'b0;
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
        end else begin
            scratch_q     <= scratch_d;
            ctrl_q        <= ctrl_d;
            status_meta_q <= status_meta_d;
            status_q      <= status_d;
            irq_flags_q   <= irq_flags_d;
            irq_mask_q    <= irq_mask_d;
            cnt_en_q      <= cnt_en_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            irq_q         <= irq_d;
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= gpr_d[i];
        end
    end

    assign ctrl_out = ctrl_q;
    assign irq_out  = irq_q;
endmodule

// File: tb/tb_uart_reg_bank.sv
// tb/tb_uart_reg_bank.sv - scoreboard bench for uart_reg_bank
module tb_uart_reg_bank;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] address = 8'h00;
    logic [7:0] data_write_to_reg = 8'h00;
    logic [7:0] data_read_from_reg;
    logic       reg_en = 1'b0;
    logic       write_en = 1'b0;
    logic [7:0] status_in = 8'h00;
    logic [7:0] irq_event = 8'h00;
    logic       cnt_tick = 1'b0;
    logic [7:0] ctrl_out;
    logic       irq_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    uart_reg_bank dut (
        .clk(clk), .reset(reset), .address(address),
        .data_write_to_reg(data_write_to_reg), .data_read_from_reg(data_read_from_reg),
        .reg_en(reg_en), .write_en(write_en), .status_in(status_in),
        .irq_event(irq_event), .cnt_tick(cnt_tick), .ctrl_out(ctrl_out), .irq_out(irq_out)
    );

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        address = a; data_write_to_reg = d; reg_en = 1'b1; write_en = 1'b1;
        @(negedge clk);
        reg_en = 1'b0; write_en = 1'b0;
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
        address = a; reg_en = 1'b1; write_en = 1'b0;
        #1 d = data_read_from_reg;
        @(negedge clk);
        reg_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] addrs [9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        logic [7:0] got, exp_v;
        repeat (3) @(negedge clk);
        checks++;
        if (data_read_from_reg !== 8'hA5) begin
            errors++; $display("FAIL reset_id_during_reset: got %h expected a5", data_read_from_reg);
        end
        reset = 1'b0;
        checks++;
        if (ctrl_out !== 8'h00 || irq_out !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: ctrl_out %h irq_out %b expected 00 0", ctrl_out, irq_out);
        end
        foreach (addrs[i]) sb.push_back(addrs[i] == 8'h00 ? 8'hA5 : (addrs[i] == 8'h01 ? 8'h01 : 8'h00));
        foreach (addrs[i]) begin
            rd_reg(addrs[i], got);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL reset_read_%h: got %h expected %h", addrs[i], got, exp_v);
            end
        end
    endtask

    task automatic test_basic_rw();
        logic [7:0] addrs [5] = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h04};
        logic [7:0] got, exp_v;
        wr_reg(8'h02, 8'h3C); sb.push_back(8'h3C);
        sb.push_back(8'hA5);
        wr_reg(8'h20, 8'h99); sb.push_back(8'h00);
        wr_reg(8'h00, 8'h55); sb.push_back(8'hA5);
        status_in = 8'h3C;
        repeat (2) @(negedge clk);
        sb.push_back(8'h3C);
        foreach (addrs[i]) begin
            rd_reg(addrs[i], got);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL basic_read_%h: got %h expected %h", addrs[i], got, exp_v);
            end
        end
    endtask

    task automatic test_irq();
        logic [7:0] got, exp_v;
        irq_event = 8'h81; @(negedge clk); irq_event = 8'h00;
        sb.push_back(8'h81);
        rd_reg(8'h05, got); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL irq_flags_set: got %h expected %h", got, exp_v); end
        checks++;
        if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", irq_out); end
        wr_reg(8'h06, 8'h01);
        checks++;
        if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b expected 0", irq_out); end
        @(negedge clk);
        checks++;
        if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_unmasked: got %b expected 1", irq_out); end
        address = 8'h05; data_write_to_reg = 8'h01; reg_en = 1'b1; write_en = 1'b1; irq_event = 8'h01;
        @(negedge clk);
        reg_en = 1'b0; write_en = 1'b0; irq_event = 8'h00;
        sb.push_back(8'h81);
        rd_reg(8'h05, got); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL irq_set_beats_clear: got %h expected %h", got, exp_v); end
        wr_reg(8'h05, 8'h81);
        @(negedge clk);
        checks++;
        if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", irq_out); end
        sb.push_back(8'h00);
        rd_reg(8'h05, got); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL irq_flags_clear: got %h expected %h", got, exp_v); end
    endtask

    task automatic test_counter();
        logic [7:0] addrs [5] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h07};
        logic [7:0] got, exp_v;
        wr_reg(8'h07, 8'h01);
        cnt_tick = 1'b1; repeat (300) @(negedge clk); cnt_tick = 1'b0;
        sb.push_back(8'h2C);
        rd_reg(8'h08, got); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL cnt_byte0: got %h expected %h", got, exp_v); end
        cnt_tick = 1'b1; repeat (300) @(negedge clk); cnt_tick = 1'b0;
        sb.push_back(8'h01); sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h58);
        for (int i = 1; i < 5; i++) begin
            rd_reg(addrs[i], got); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL cnt_shadow_%h: got %h expected %h", addrs[i], got, exp_v); end
        end
        rd_reg(8'h08, got); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL cnt_live: got %h expected %h", got, exp_v); end
    endtask

    task automatic test_wrap_and_clear();
        logic [7:0] got, exp_v;
        dut.cnt_q = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) sb.push_back(8'hFF);
        for (int i = 0; i < 4; i++) begin
            rd_reg(8'h08 + 8'(i), got); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL cnt_max_b%0d: got %h expected %h", i, got, exp_v); end
        end
        cnt_tick = 1'b1; @(negedge clk); cnt_tick = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back(8'h00);
        for (int i = 0; i < 4; i++) begin
            rd_reg(8'h08 + 8'(i), got); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL cnt_wrap_b%0d: got %h expected %h", i, got, exp_v); end
        end
        cnt_tick = 1'b1; repeat (5) @(negedge clk);
        address = 8'h07; data_write_to_reg = 8'h03; reg_en = 1'b1; write_en = 1'b1;
        @(negedge clk);
        reg_en = 1'b0; write_en = 1'b0; cnt_tick = 1'b0;
        sb.push_back(8'h00); sb.push_back(8'h01);
        rd_reg(8'h08, got); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL cnt_clear_beats_tick: got %h expected %h", got, exp_v); end
        rd_reg(8'h07, got); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL cnt_ctrl_read: got %h expected %h", got, exp_v); end
        cnt_tick = 1'b1; @(negedge clk); cnt_tick = 1'b0;
        sb.push_back(8'h01);
        rd_reg(8'h08, got); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL cnt_enable_kept: got %h expected %h", got, exp_v); end
    endtask

    task automatic test_gpr_ctrl();
        logic [7:0] got, exp_v;
        for (int i = 0; i < 16; i++) begin
            wr_reg(8'h10 + 8'(i), 8'hA0 + 8'(i));
            sb.push_back(8'hA0 + 8'(i));
        end
        for (int i = 0; i < 16; i++) begin
            rd_reg(8'h10 + 8'(i), got); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL gpr_%0d: got %h expected %h", i, got, exp_v); end
        end
        wr_reg(8'h03, 8'h5A);
        checks++;
        if (ctrl_out !== 8'h5A) begin errors++; $display("FAIL ctrl_out: got %h expected 5a", ctrl_out); end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] addrs [12] = '{8'h04, 8'h00, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07,
                                   8'h09, 8'h0A, 8'h0B, 8'h08, 8'h10};
        logic [7:0] got, exp_v;
        logic [7:0] junk;
        status_in = 8'hFF;
        wr_reg(8'h02, 8'h11);
        wr_reg(8'h06, 8'hFF);
        irq_event = 8'hFF; @(negedge clk); irq_event = 8'h00;
        cnt_tick = 1'b1; repeat (300) @(negedge clk); cnt_tick = 1'b0;
        rd_reg(8'h08, junk);
        @(negedge clk);
        checks++;
        if (irq_out !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", irq_out); end
        address = 8'h02; data_write_to_reg = 8'h77; reg_en = 1'b1; write_en = 1'b1;
        cnt_tick = 1'b1; irq_event = 8'hFF; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; reg_en = 1'b0; write_en = 1'b0; cnt_tick = 1'b0; irq_event = 8'h00;
        checks++;
        if (ctrl_out !== 8'h00 || irq_out !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: ctrl_out %h irq_out %b expected 00 0", ctrl_out, irq_out);
        end
        foreach (addrs[i]) sb.push_back(addrs[i] == 8'h00 ? 8'hA5 : 8'h00);
        foreach (addrs[i]) begin
            rd_reg(addrs[i], got); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL mid_reset_read_%h: got %h expected %h", addrs[i], got, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_irq();
        test_counter();
        test_wrap_and_clear();
        test_gpr_ctrl();
        test_reset_mid_op();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
